// File: rtl/mcu_bus_pkg.sv
// Shared constants and types for the CPU external memory responder.
package mcu_bus_pkg;

   localparam int unsigned DATA_W          = 8;
   localparam int unsigned ADDR_W          = 16;
   localparam int unsigned MAX_WAIT_STATES = 15;
   localparam int unsigned CNT_W           = 4;

   localparam logic MEMSEL_ROM = 1'b0;
   localparam logic MEMSEL_RAM = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_WRITE = 2'd3
   } resp_state_t;

   // Wait-state count clamped to what the counter can hold.
   function automatic logic [CNT_W-1:0] clamp_wait(input int unsigned ws);
      if (ws > MAX_WAIT_STATES) begin
         return CNT_W'(MAX_WAIT_STATES);
      end
      return CNT_W'(ws);
   endfunction

endpackage

// File: rtl/sp_sync_ram.sv
// Single-port synchronous RAM: registered read (one clock), write-first-not, read returns old data.
module sp_sync_ram #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   // Array write and registered read; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/ext_mem_responder.sv
// Bus-side responder answering CPU read/write strobes from a program ROM or data RAM.
module ext_mem_responder
   import mcu_bus_pkg::*;
#(
   parameter int unsigned ROM_AW      = 12,
   parameter int unsigned RAM_AW      = 8,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_bus,
   inout  wire  [DATA_W-1:0] data_bus,
   input  logic              read_en,
   input  logic              write_en,
   input  logic              memory_select,
   input  logic              load_valid,
   input  logic [ROM_AW-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              bus_busy,
   output logic              prot_err
);

   localparam int unsigned LAT_W = (ROM_AW > RAM_AW) ? ROM_AW : RAM_AW;
   localparam logic [CNT_W-1:0] WAIT_LOAD = clamp_wait(WAIT_STATES);

   resp_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LAT_W-1:0]  addr_q, addr_d;
   logic              sel_q, sel_d;
   logic              armed_q, armed_d;
   logic              wr_first_q, wr_first_d;
   logic              perr_q, perr_d;

   logic              ram_we_c;
   logic              rom_we_c;
   logic [RAM_AW-1:0] ram_addr_c;
   logic [ROM_AW-1:0] rom_rd_addr_c;
   logic [ROM_AW-1:0] rom_addr_c;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] rom_rdata;
   logic [DATA_W-1:0] rd_byte_c;
   logic              oe_c;
   logic              unused_addr_c;

   // Address bits above the widest array alias onto lower locations.
   assign unused_addr_c = ^addr_bus[ADDR_W-1:LAT_W];

   // State and datapath registers; async reset releases the bus at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         sel_q      <= MEMSEL_ROM;
         armed_q    <= 1'b1;
         wr_first_q <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         sel_q      <= sel_d;
         armed_q    <= armed_d;
         wr_first_q <= wr_first_d;
         perr_q     <= perr_d;
      end
   end

   // Next-state logic: capture accesses in IDLE, count wait states, commit one write per strobe.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      armed_d    = armed_q;
      wr_first_d = 1'b0;
      perr_d     = perr_q;
      ram_we_c   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (read_en && write_en) begin
               perr_d = 1'b1;
            end else if (armed_q && read_en) begin
               addr_d  = addr_bus[LAT_W-1:0];
               sel_d   = memory_select;
               cnt_d   = WAIT_LOAD;
               armed_d = 1'b0;
               state_d = (WAIT_LOAD != '0) ? ST_WAIT : ST_DRIVE;
            end else if (armed_q && write_en) begin
               addr_d     = addr_bus[LAT_W-1:0];
               sel_d      = memory_select;
               armed_d    = 1'b0;
               wr_first_d = 1'b1;
               state_d    = ST_WRITE;
            end else if (!read_en && !write_en) begin
               armed_d = 1'b1;
            end
         end

         ST_WAIT: begin
            if (!read_en) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_DRIVE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_DRIVE: begin
            state_d = ST_IDLE;
         end

         ST_WRITE: begin
            if (wr_first_q && write_en) begin
               if (sel_q == MEMSEL_RAM) begin
                  ram_we_c = 1'b1;
               end else begin
                  perr_d = 1'b1;
               end
            end
            if (!write_en) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Array addressing: live bus address in IDLE so the read is issued on the capture edge.
   always_comb begin
      ram_addr_c    = addr_q[RAM_AW-1:0];
      rom_rd_addr_c = addr_q[ROM_AW-1:0];
      if (state_q == ST_IDLE) begin
         ram_addr_c    = addr_bus[RAM_AW-1:0];
         rom_rd_addr_c = addr_bus[ROM_AW-1:0];
      end
      rom_addr_c = rom_we_c ? load_addr : rom_rd_addr_c;
   end

   assign load_ready = (state_q == ST_IDLE) && !read_en && !write_en;
   assign rom_we_c   = load_valid && load_ready;
   assign bus_busy   = (state_q != ST_IDLE);
   assign prot_err   = perr_q;

   // Bus driver gated by the live strobe so it releases in the cycle read_en falls.
   assign rd_byte_c = (sel_q == MEMSEL_RAM) ? ram_rdata : rom_rdata;
   assign oe_c      = (state_q == ST_DRIVE) && read_en;
   assign data_bus  = oe_c ? rd_byte_c : {DATA_W{1'bz}};

   sp_sync_ram #(
      .AW (ROM_AW),
      .DW (DATA_W)
   ) u_rom (
      .clk   (clk),
      .we    (rom_we_c),
      .addr  (rom_addr_c),
      .wdata (load_data),
      .rdata (rom_rdata)
   );

   sp_sync_ram #(
      .AW (RAM_AW),
      .DW (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we_c),
      .addr  (ram_addr_c),
      .wdata (data_bus),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder; a weak pull-down makes a released bus read as 0x00.
module tb_ext_mem_responder;

   logic        clk;
   logic        rst;
   logic [15:0] addr_bus;
   wire  [7:0]  data_bus;
   logic        read_en;
   logic        write_en;
   logic        memory_select;
   logic        load_valid;
   logic [11:0] load_addr;
   logic [7:0]  load_data;
   logic        load_ready;
   logic        bus_busy;
   logic        prot_err;

   logic [7:0]  tb_drv;
   logic        tb_oe;

   int tests;
   int fails;

   localparam logic [7:0] REL = 8'h00;

   assign data_bus = tb_oe ? tb_drv : 8'bz;

   for (genvar i = 0; i < 8; i++) begin : g_pd
      pulldown pd (data_bus[i]);
   end

   ext_mem_responder #(
      .ROM_AW      (12),
      .RAM_AW      (8),
      .WAIT_STATES (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .addr_bus      (addr_bus),
      .data_bus      (data_bus),
      .read_en       (read_en),
      .write_en      (write_en),
      .memory_select (memory_select),
      .load_valid    (load_valid),
      .load_addr     (load_addr),
      .load_data     (load_data),
      .load_ready    (load_ready),
      .bus_busy      (bus_busy),
      .prot_err      (prot_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full read with WAIT_STATES=1: bus driven after the third edge, released when read_en drops.
   task automatic do_read(input string tag, input logic [15:0] a, input logic sel,
                          input logic [7:0] exp);
      addr_bus      = a;
      memory_select = sel;
      read_en       = 1'b1;
      tick();
      check({tag, "_busy"}, 8'(bus_busy), 8'h01);
      check({tag, "_wait1"}, data_bus, REL);
      tick();
      check({tag, "_wait2"}, data_bus, REL);
      tick();
      check({tag, "_data"}, data_bus, exp);
      read_en = 1'b0;
      #1;
      check({tag, "_rel"}, data_bus, REL);
      tick();
      tick();
   endtask

   task automatic do_write(input logic [15:0] a, input logic sel, input logic [7:0] d);
      addr_bus      = a;
      memory_select = sel;
      tb_drv        = d;
      tb_oe         = 1'b1;
      write_en      = 1'b1;
      tick();
      tick();
      write_en = 1'b0;
      tb_oe    = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      rst           = 1'b1;
      addr_bus      = '0;
      read_en       = 1'b0;
      write_en      = 1'b0;
      memory_select = 1'b0;
      load_valid    = 1'b0;
      load_addr     = '0;
      load_data     = '0;
      tb_drv        = '0;
      tb_oe         = 1'b0;

      // Reset state
      #2;
      check("rst_bus", data_bus, REL);
      check("rst_load_ready", 8'(load_ready), 8'h01);
      check("rst_busy", 8'(bus_busy), 8'h00);
      check("rst_perr", 8'(prot_err), 8'h00);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // 1: preload ROM then read it
      load_valid = 1'b1;
      load_addr  = 12'h010;
      load_data  = 8'hB4;
      #1;
      check("t1_load_ready", 8'(load_ready), 8'h01);
      tick();
      load_valid = 1'b0;
      check("t1_idle_busy", 8'(bus_busy), 8'h00);
      do_read("t1_rom", 16'h0010, 1'b0, 8'hB4);

      // 2: RAM write, read back, upper address bits alias
      do_write(16'h0030, 1'b1, 8'h50);
      do_read("t2_ram", 16'h0030, 1'b1, 8'h50);
      do_read("t2_alias", 16'h0130, 1'b1, 8'h50);

      // 3: only the first edge of a long write strobe commits
      addr_bus      = 16'h0040;
      memory_select = 1'b1;
      tb_drv        = 8'h11;
      tb_oe         = 1'b1;
      write_en      = 1'b1;
      tick();
      check("t3_busy", 8'(bus_busy), 8'h01);
      tick();
      tb_drv = 8'h22;
      tick();
      tick();
      write_en = 1'b0;
      tb_oe    = 1'b0;
      tick();
      tick();
      do_read("t3_first", 16'h0040, 1'b1, 8'h11);

      // 4a: simultaneous strobes flag an error, nothing driven, RAM intact
      addr_bus      = 16'h0030;
      memory_select = 1'b1;
      tb_drv        = 8'h99;
      tb_oe         = 1'b1;
      read_en       = 1'b1;
      write_en      = 1'b1;
      tick();
      check("t4_perr", 8'(prot_err), 8'h01);
      check("t4_busy", 8'(bus_busy), 8'h00);
      tb_oe = 1'b0;
      #1;
      check("t4_bus", data_bus, REL);
      read_en  = 1'b0;
      write_en = 1'b0;
      tick();
      tick();
      check("t4_sticky", 8'(prot_err), 8'h01);
      do_read("t4_ram", 16'h0030, 1'b1, 8'h50);

      // 4b: after reset, a ROM write flags an error and leaves ROM untouched
      rst = 1'b1;
      #1;
      check("t4_rst_perr", 8'(prot_err), 8'h00);
      tick();
      rst = 1'b0;
      tick();
      do_write(16'h0010, 1'b0, 8'h77);
      check("t4_rom_perr", 8'(prot_err), 8'h01);
      do_read("t4_rom", 16'h0010, 1'b0, 8'hB4);

      // 5: load blocked while a read is in flight, accepted once idle
      load_valid    = 1'b1;
      load_addr     = 12'h010;
      load_data     = 8'hEE;
      addr_bus      = 16'h0010;
      memory_select = 1'b0;
      read_en       = 1'b1;
      #1;
      check("t5_blocked", 8'(load_ready), 8'h00);
      do_read("t5_rom_old", 16'h0010, 1'b0, 8'hB4);
      check("t5_ready", 8'(load_ready), 8'h01);
      load_valid = 1'b0;
      do_read("t5_rom_new", 16'h0010, 1'b0, 8'hEE);

      // Held read_en does not retrigger after DRIVE
      addr_bus      = 16'h0030;
      memory_select = 1'b1;
      read_en       = 1'b1;
      tick();
      tick();
      tick();
      check("b2b_data", data_bus, 8'h50);
      tick();
      check("b2b_idle", 8'(bus_busy), 8'h00);
      check("b2b_rel", data_bus, REL);
      tick();
      check("b2b_noretrig", 8'(bus_busy), 8'h00);
      read_en = 1'b0;
      tick();
      tick();

      // Aborted read returns to IDLE without driving
      read_en = 1'b1;
      tick();
      check("abort_busy", 8'(bus_busy), 8'h01);
      read_en = 1'b0;
      tick();
      check("abort_idle", 8'(bus_busy), 8'h00);
      check("abort_bus", data_bus, REL);
      tick();

      // 6: reset during DRIVE releases the bus immediately, arrays retained
      addr_bus      = 16'h0030;
      memory_select = 1'b1;
      read_en       = 1'b1;
      tick();
      tick();
      tick();
      check("t6_data", data_bus, 8'h50);
      rst = 1'b1;
      #1;
      check("t6_rel", data_bus, REL);
      check("t6_busy", 8'(bus_busy), 8'h00);
      tick();
      rst     = 1'b0;
      read_en = 1'b0;
      tick();
      do_read("t6_ram", 16'h0030, 1'b1, 8'h50);
      do_read("t6_rom", 16'h0010, 1'b0, 8'hEE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
